audio_frame_buffer: RTL and testbench
=====================================

# audio_frame_buffer

Collects a stream of signed audio samples into an N-sample frame and launches the downstream `audio_min_max` stage on it. Drives that stage's `raw_audio`, `reset` and `start` inputs and watches its `d` output. It captures `out_min`/`out_max` into result registers when the stage finishes. The frame is held stable for the whole computation, and a watchdog recovers if the consumer never finishes.

## Interface
- `N`, 100: samples per frame; must match the consumer's N.
- `W`, 32: sample width, signed.
- `TIMEOUT`, 1024: maximum WAIT cycles before abort; must be greater than the consumer's worst-case latency.
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  `in_sample` is valid this cycle.
- `in_ready`  out  1  block accepts a sample this cycle.
- `in_sample`  in  W signed  incoming audio sample.
- `frame`  out  [N-1:0] × W signed  frame storage; connects to the consumer's `raw_audio`.
- `mm_reset`  out  1  active-high reset pulse to the consumer.
- `mm_start`  out  1  one-cycle start pulse to the consumer.
- `mm_done`  in  1  consumer `d`.
- `mm_min`, `mm_max`  in  W signed  consumer `out_min` / `out_max`.
- `result_min`, `result_max`  out  W signed  last captured frame extremes.
- `result_valid`  out  1  one-cycle pulse when the results update.
- `frame_count`  out  16  completed frames; wraps from 65535 to 0.
- `timeout_err`  out  1  sticky; set on watchdog abort.

## Operation
- States: FILL, CLEAR, LAUNCH, WAIT.
- FILL:
  - `in_ready`=1.
  - A sample is accepted on `in_valid && in_ready`: `frame[wr_idx] <= in_sample`, then `wr_idx` increments.
  - Accepting the sample at `wr_idx==N-1` sets `wr_idx`←0 and moves to CLEAR.
- CLEAR: `mm_reset`=1 for exactly one cycle, then go to LAUNCH.
- LAUNCH: `mm_start`=1 for exactly one cycle, then go to WAIT. The watchdog counter clears to 0.
- WAIT:
  - `mm_done` is ignored in the first WAIT cycle, so a stale `d` is never taken as completion.
  - From the second WAIT cycle on, `mm_done`=1 does the following in the same edge: capture `mm_min`/`mm_max` into `result_min`/`result_max`, pulse `result_valid`, increment `frame_count`, and return to FILL.
  - Otherwise the watchdog increments. When it reaches TIMEOUT the block sets `timeout_err`, returns to FILL and leaves the results untouched.
- `frame` changes only on accepted samples in FILL. It is stable from CLEAR through the end of WAIT.
- `in_ready`=0 in CLEAR, LAUNCH and WAIT. This is backpressure; samples are never dropped.
- `in_sample` is stored bit-exact with no arithmetic. Results are copied verbatim, sign preserved.
- Only reset clears `timeout_err`.

## Timing
- Reset (`reset`=0 at a rising edge):
  - Values after the edge: state FILL, `wr_idx` 0, all `frame` entries 0, `result_min`/`result_max` 0, `frame_count` 0.
  - `result_valid`, `mm_start` and `timeout_err` are 0.
  - `mm_reset` is 1 while `reset`=0, so the consumer is also held in reset.
  - `in_ready` is forced to 0 while `reset`=0.
- If reset is asserted mid-operation, in any state, it aborts at the next edge. Partial frames are discarded and no `result_valid` is produced.
- Latency, with the last sample accepted at edge k:
  - `mm_reset`=1 during cycle k+1.
  - `mm_start`=1 during cycle k+2.
  - WAIT begins at cycle k+3, and `mm_done` is first honoured in cycle k+4.
- Completion: with `mm_done` sampled high at edge m, `result_*` and `result_valid`=1 are visible after edge m. `in_ready`=1 in the same cycle, so the first sample of the next frame can be accepted at edge m+1.
- `in_valid` high in a non-FILL state has no effect.
- `mm_start` and `mm_reset` are registered outputs and are never high in the same cycle.
- Throughput: one sample per cycle in FILL, with a minimum of 3 idle-input cycles plus the consumer latency per frame.

## Test plan
- Ramp: after reset, stream `i` for i=0..99 with `in_valid` held high. Required: `mm_reset` at k+1, `mm_start` at k+2. With the real `audio_min_max` attached: `result_min`=0, `result_max`=99, `result_valid` pulses once, `frame_count`=1.
- Backpressure: keep `in_valid` high through WAIT. Required: no writes outside FILL, and `frame` is unchanged until the next frame's first accepted sample, which is written to `frame[0]`.
- Stale done: a consumer model holds `mm_done`=1 into the first WAIT cycle, then drops it and reasserts 20 cycles later. Required: completion occurs at the reassertion, not at the first WAIT cycle.
- Timeout: the consumer never asserts done, with TIMEOUT=16. Required: return to FILL 16 cycles into WAIT, `timeout_err`=1, results unchanged, no `result_valid`.
- Mid-frame reset: pull `reset` low after 50 samples, then stream a full frame of 42. Required: the result is min=max=42 and `frame_count`=1.
- Alternating ±100 for two back-to-back frames. Required: min=-100, max=100 on both frames, and `frame_count`=2.

Source files
------------

// File: rtl/audio_frame_buffer_if.sv
// Bundle between audio_frame_buffer and its surroundings: sample stream in,
// frame plus control out to the min/max consumer, and the captured results.
interface audio_frame_buffer_if #(
    parameter int N = 100,
    parameter int W = 32
);
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_sample;
    logic signed [W-1:0] frame [N];
    logic                mm_reset;
    logic                mm_start;
    logic                mm_done;
    logic signed [W-1:0] mm_min;
    logic signed [W-1:0] mm_max;
    logic signed [W-1:0] result_min;
    logic signed [W-1:0] result_max;
    logic                result_valid;
    logic [15:0]         frame_count;
    logic                timeout_err;

    // The frame buffer itself drives everything it owns through master.
    modport master (
        input  in_valid, in_sample, mm_done, mm_min, mm_max,
        output in_ready, frame, mm_reset, mm_start,
               result_min, result_max, result_valid, frame_count, timeout_err
    );

    modport slave (
        output in_valid, in_sample, mm_done, mm_min, mm_max,
        input  in_ready, frame, mm_reset, mm_start,
               result_min, result_max, result_valid, frame_count, timeout_err
    );
endinterface

// File: rtl/audio_frame_buffer.sv
// Gathers N signed samples into a frame, launches the min/max consumer on it,
// captures its extremes and recovers through a watchdog if it never finishes.
module audio_frame_buffer #(
    parameter int N       = 100,
    parameter int W       = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    audio_frame_buffer_if.master bus
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        CLEAR  = 2'd1,
        LAUNCH = 2'd2,
        WAIT   = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [IDX_W-1:0]    wr_idx_r;
    logic [IDX_W-1:0]    wr_idx_next_s;
    logic [WD_W-1:0]     wd_r;
    logic [WD_W-1:0]     wd_next_s;
    logic                accept_s;
    logic                capture_s;
    logic                abort_s;
    logic                in_ready_r;
    logic                mm_reset_r;
    logic                mm_start_r;
    logic signed [W-1:0] frame_r [N];
    logic signed [W-1:0] result_min_r;
    logic signed [W-1:0] result_max_r;
    logic                result_valid_r;
    logic [15:0]         frame_count_r;
    logic                timeout_err_r;

    // Next-state, write index and watchdog decisions for the frame sequencer.
    always_comb begin
        state_next_s  = state_r;
        wr_idx_next_s = wr_idx_r;
        wd_next_s     = wd_r;
        accept_s      = 1'b0;
        capture_s     = 1'b0;
        abort_s       = 1'b0;
        case (state_r)
            FILL: begin
                if (bus.in_valid) begin
                    accept_s = 1'b1;
                    if (wr_idx_r == IDX_W'(N - 1)) begin
                        wr_idx_next_s = {IDX_W{1'b0}};
                        state_next_s  = CLEAR;
                    end else begin
                        wr_idx_next_s = wr_idx_r + IDX_W'(1'b1);
                    end
                end else begin
                    accept_s = 1'b0;
                end
            end
            CLEAR: begin
                state_next_s = LAUNCH;
            end
            LAUNCH: begin
                state_next_s = WAIT;
                wd_next_s    = {WD_W{1'b0}};
            end
            WAIT: begin
                // wd_r is still zero only in the first WAIT cycle, where a
                // leftover done from the previous run must not count.
                if (bus.mm_done && (wd_r != {WD_W{1'b0}})) begin
                    capture_s    = 1'b1;
                    state_next_s = FILL;
                end else if (wd_r == WD_W'(TIMEOUT - 1)) begin
                    abort_s      = 1'b1;
                    wd_next_s    = WD_W'(TIMEOUT);
                    state_next_s = FILL;
                end else begin
                    wd_next_s = wd_r + WD_W'(1'b1);
                end
            end
            default: begin
                state_next_s = FILL;
            end
        endcase
    end

    // Sequencer state plus the registered handshake and consumer strobes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= FILL;
            wr_idx_r   <= {IDX_W{1'b0}};
            wd_r       <= {WD_W{1'b0}};
            in_ready_r <= 1'b1;
            mm_reset_r <= 1'b0;
            mm_start_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            wr_idx_r   <= wr_idx_next_s;
            wd_r       <= wd_next_s;
            in_ready_r <= (state_next_s == FILL);
            mm_reset_r <= (state_next_s == CLEAR);
            mm_start_r <= (state_next_s == LAUNCH);
        end
    end

    // Frame storage, captured results, frame counter and sticky watchdog flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                frame_r[i] <= {W{1'b0}};
            end
            result_min_r   <= {W{1'b0}};
            result_max_r   <= {W{1'b0}};
            result_valid_r <= 1'b0;
            frame_count_r  <= 16'd0;
            timeout_err_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                frame_r[wr_idx_r] <= bus.in_sample;
            end
            if (capture_s) begin
                result_min_r  <= bus.mm_min;
                result_max_r  <= bus.mm_max;
                frame_count_r <= frame_count_r + 16'd1;
            end
            if (abort_s) begin
                timeout_err_r <= 1'b1;
            end
            result_valid_r <= capture_s;
        end
    end

    // Reset overrides the registered strobes so the consumer is held in reset
    // and no sample is offered acceptance while the block itself is in reset.
    assign bus.in_ready     = in_ready_r & reset;
    assign bus.mm_reset     = mm_reset_r | ~reset;
    assign bus.mm_start     = mm_start_r;
    assign bus.frame        = frame_r;
    assign bus.result_min   = result_min_r;
    assign bus.result_max   = result_max_r;
    assign bus.result_valid = result_valid_r;
    assign bus.frame_count  = frame_count_r;
    assign bus.timeout_err  = timeout_err_r;
endmodule

// File: tb/tb_audio_frame_buffer.sv
// Randomised bench for audio_frame_buffer with a behavioural min/max consumer
// whose done timing is chosen per frame (normal, stale done, never done).
module tb_audio_frame_buffer;
    localparam int N       = 100;
    localparam int W       = 32;
    localparam int TIMEOUT = 32;
    localparam int M_NORMAL = 0;
    localparam int M_STALE  = 1;
    localparam int M_NEVER  = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    audio_frame_buffer_if #(.N(N), .W(W)) bus ();
    audio_frame_buffer #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    logic signed [W-1:0] stim [N];
    logic signed [W-1:0] model_frame [N];
    logic signed [W-1:0] exp_min;
    logic signed [W-1:0] exp_max;
    logic [15:0]         exp_count;
    logic                exp_terr;
    int cons_mode = M_NORMAL;
    int cons_lat  = 4;

    // Is done high t cycles after the consumer saw its start strobe?
    function automatic bit done_at(input int mode, input int lat, input int t);
        if (mode == M_NORMAL) return t >= lat;
        if (mode == M_STALE)  return (t <= 1) || (t >= 22);
        return 1'b0;
    endfunction

    // Consumer model: min/max of the frame, done held until its next reset.
    int c_t = 0;
    bit c_busy = 1'b0;
    logic signed [W-1:0] c_min, c_max;
    always @(negedge clk) begin
        if (bus.mm_reset === 1'b1) begin
            c_busy = 1'b0;
            bus.mm_done = 1'b0;
            bus.mm_min = 32'sd0;
            bus.mm_max = 32'sd0;
        end else if (bus.mm_start === 1'b1 || c_busy) begin
            if (bus.mm_start === 1'b1) begin
                c_busy = 1'b1;
                c_t = 0;
                c_min = bus.frame[0];
                c_max = bus.frame[0];
                for (int i = 1; i < N; i++) begin
                    if (bus.frame[i] < c_min) c_min = bus.frame[i];
                    if (bus.frame[i] > c_max) c_max = bus.frame[i];
                end
            end else begin
                c_t++;
            end
            bus.mm_done = done_at(cons_mode, cons_lat, c_t);
            if (cons_mode == M_STALE && c_t <= 1) begin
                bus.mm_min = 32'sh1234_5678;
                bus.mm_max = -32'sh1234_5678;
            end else begin
                bus.mm_min = c_min;
                bus.mm_max = c_max;
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < N; i++) model_frame[i] = 32'sd0;
        exp_min = 32'sd0;
        exp_max = 32'sd0;
        exp_count = 16'd0;
        exp_terr = 1'b0;
    endtask

    task automatic do_frame(input int mode, input int lat, input bit hold_valid);
        int idx = 0;
        int budget = 0;
        int t = 0;
        int t_exp;
        bit v;
        bit first_pending = 1'b0;
        bit ok;
        bit stable = 1'b1;
        logic signed [W-1:0] fmin = stim[0];
        logic signed [W-1:0] fmax = stim[0];
        for (int i = 1; i < N; i++) begin
            if (stim[i] < fmin) fmin = stim[i];
            if (stim[i] > fmax) fmax = stim[i];
        end
        cons_mode = mode;
        cons_lat = lat;
        while (idx < N && budget < 20 * N) begin
            @(negedge clk);
            budget++;
            if (first_pending) begin
                first_pending = 1'b0;
                ok = 1'b1;
                for (int i = 0; i < N; i++) if (bus.frame[i] !== model_frame[i]) ok = 1'b0;
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL first_sample: frame[0]=%0d required %0d (or other entries moved)", bus.frame[0], stim[0]);
                end
            end
            v = hold_valid || ($urandom_range(0, 3) != 0);
            bus.in_valid = v;
            bus.in_sample = v ? stim[idx] : $urandom;
            if (v && bus.in_ready === 1'b1) begin
                model_frame[idx] = stim[idx];
                if (idx == 0) first_pending = 1'b1;
                idx++;
            end
        end
        checks++;
        if (idx != N) begin
            errors++;
            $display("FAIL fill: accepted %0d samples required %0d", idx, N);
            bus.in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        checks++;
        if (bus.mm_reset !== 1'b1 || bus.mm_start !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_cycle: mm_reset=%b mm_start=%b in_ready=%b required 1 0 0", bus.mm_reset, bus.mm_start, bus.in_ready);
        end
        ok = 1'b1;
        for (int i = 0; i < N; i++) if (bus.frame[i] !== model_frame[i]) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL frame_content: frame differs from accepted samples (frame[%0d]=%0d required %0d)", N - 1, bus.frame[N-1], model_frame[N-1]);
        end
        bus.in_valid = hold_valid;
        bus.in_sample = $urandom;
        @(negedge clk);
        checks++;
        if (bus.mm_start !== 1'b1 || bus.mm_reset !== 1'b0) begin
            errors++;
            $display("FAIL launch_cycle: mm_start=%b mm_reset=%b required 1 0", bus.mm_start, bus.mm_reset);
        end
        bus.in_sample = $urandom;
        if (mode == M_NEVER) begin
            t_exp = TIMEOUT + 1;
        end else begin
            t_exp = 2;
            while (!done_at(mode, lat, t_exp)) t_exp++;
            t_exp = t_exp + 1;
        end
        while (t < TIMEOUT + 10) begin
            @(negedge clk);
            t++;
            for (int i = 0; i < N; i++) if (bus.frame[i] !== model_frame[i]) stable = 1'b0;
            if (bus.result_valid === 1'b1 || bus.in_ready === 1'b1) break;
            bus.in_sample = $urandom;
        end
        bus.in_valid = 1'b0;
        if (mode != M_NEVER) begin
            exp_min = fmin;
            exp_max = fmax;
            exp_count = exp_count + 16'd1;
        end else begin
            exp_terr = 1'b1;
        end
        checks++;
        if (t != t_exp) begin
            errors++;
            $display("FAIL completion_time: %0d cycles after start required %0d", t, t_exp);
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL frame_stable: frame changed while waiting, required unchanged");
        end
        checks++;
        if (bus.result_valid !== (mode != M_NEVER) || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL completion_flags: result_valid=%b in_ready=%b required %b 1", bus.result_valid, bus.in_ready, mode != M_NEVER);
        end
        checks++;
        if (bus.result_min !== exp_min || bus.result_max !== exp_max) begin
            errors++;
            $display("FAIL results: min=%0d max=%0d required %0d %0d", bus.result_min, bus.result_max, exp_min, exp_max);
        end
        checks++;
        if (bus.frame_count !== exp_count || bus.timeout_err !== exp_terr) begin
            errors++;
            $display("FAIL counters: frame_count=%0d timeout_err=%b required %0d %b", bus.frame_count, bus.timeout_err, exp_count, exp_terr);
        end
        @(negedge clk);
        checks++;
        if (bus.result_valid !== 1'b0) begin
            errors++;
            $display("FAIL rv_pulse: result_valid=%b a cycle later required 0", bus.result_valid);
        end
    endtask

    task automatic test_reset();
        bit ok = 1'b1;
        reset = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sample = $urandom;
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) if (bus.frame[i] !== 32'sd0) ok = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.mm_reset !== 1'b1 || bus.mm_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: in_ready=%b mm_reset=%b mm_start=%b required 0 1 0", bus.in_ready, bus.mm_reset, bus.mm_start);
        end
        checks++;
        if (bus.result_valid !== 1'b0 || bus.timeout_err !== 1'b0 || bus.frame_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_status: result_valid=%b timeout_err=%b frame_count=%0d required 0 0 0", bus.result_valid, bus.timeout_err, bus.frame_count);
        end
        checks++;
        if (!ok || bus.result_min !== 32'sd0 || bus.result_max !== 32'sd0) begin
            errors++;
            $display("FAIL reset_data: frame_zero=%b min=%0d max=%0d required 1 0 0", ok, bus.result_min, bus.result_max);
        end
        reset = 1'b1;
        bus.in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.mm_reset !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b mm_reset=%b required 1 0", bus.in_ready, bus.mm_reset);
        end
    endtask

    task automatic test_ramp();
        for (int i = 0; i < N; i++) stim[i] = i;
        do_frame(M_NORMAL, 5, 1'b1);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < N; i++) stim[i] = $urandom;
        do_frame(M_NORMAL, $urandom_range(1, 12), 1'b1);
        for (int i = 0; i < N; i++) stim[i] = $urandom;
        do_frame(M_NORMAL, 1, 1'b1);
    endtask

    task automatic test_stale_done();
        for (int i = 0; i < N; i++) stim[i] = $urandom_range(0, 2000) - 1000;
        do_frame(M_STALE, 0, 1'b0);
    endtask

    task automatic test_timeout();
        for (int i = 0; i < N; i++) stim[i] = $urandom;
        do_frame(M_NEVER, 0, 1'b1);
        for (int i = 0; i < N; i++) stim[i] = $urandom;
        do_frame(M_NORMAL, 3, 1'b0);
    endtask

    task automatic test_mid_reset();
        int idx = 0;
        while (idx < 50) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_sample = $urandom;
            if (bus.in_ready === 1'b1) idx++;
        end
        @(negedge clk);
        reset = 1'b0;
        bus.in_sample = $urandom;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.frame[0] !== 32'sd0 || bus.result_valid !== 1'b0 || bus.timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: in_ready=%b frame[0]=%0d result_valid=%b timeout_err=%b required 0 0 0 0", bus.in_ready, bus.frame[0], bus.result_valid, bus.timeout_err);
        end
        reset = 1'b1;
        bus.in_valid = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) stim[i] = 32'sd42;
        do_frame(M_NORMAL, 4, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < N; i++) stim[i] = (i % 2 == 0) ? 32'sd100 : -32'sd100;
            do_frame(M_NORMAL, $urandom_range(2, 8), f == 0);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N; i++) stim[i] = $urandom;
            do_frame(M_NORMAL, $urandom_range(1, 20), 1'b0);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sample = 32'sd0;
        test_reset();
        test_ramp();
        test_backpressure();
        test_stale_done();
        test_timeout();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
